// File: rtl/vram_pkg.sv
// Shared types and width defaults for the video tile RAM arbiter.
package vram_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    G_IDLE,
    G_VGA,
    G_CPU
  } grant_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count. A push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port tile RAM between VGA reads (priority) and buffered CPU stores,
// with a forced CPU slot after MAX_VGA_RUN consecutive VGA grants while stores wait.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_VGA_RUN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              err_overflow,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int RUN_W   = $clog2(MAX_VGA_RUN + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_VGA_RUN);

  grant_t             r_state;
  grant_t             w_grant;
  logic [RUN_W-1:0]   r_run_cnt;
  logic               r_overflow;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;

  assign cpu_stall    = (w_fifo_count == FULL_CNT);
  assign err_overflow = r_overflow;
  assign w_push       = cpu_we && !w_fifo_full;
  assign {w_head_addr, w_head_data} = w_head;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({cpu_addr, cpu_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= G_IDLE;
    end else begin
      r_state <= w_grant;
    end
  end

  // Grant decision and RAM port steering; the forced CPU slot outranks a pending VGA request.
  always_comb begin
    w_grant   = G_IDLE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    vga_gnt   = 1'b0;
    w_pop     = 1'b0;
    if (!w_fifo_empty && (r_run_cnt == RUN_MAX)) begin
      w_grant = G_CPU;
    end else if (vga_req) begin
      w_grant = G_VGA;
    end else if (!w_fifo_empty) begin
      w_grant = G_CPU;
    end
    unique case (w_grant)
      G_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
        vga_gnt  = 1'b1;
      end
      G_CPU: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_head_addr;
        mem_wdata = w_head_data;
        w_pop     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (w_grant == G_CPU) || w_fifo_empty) begin
      r_run_cnt <= '0;
    end else if ((w_grant == G_VGA) && (r_run_cnt != RUN_MAX)) begin
      r_run_cnt <= r_run_cnt + RUN_W'(1);
    end
  end

  // A store offered while stalled is lost even if the head pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (cpu_we && cpu_stall) begin
      r_overflow <= 1'b1;
    end
  end

  assign vga_rvalid = (r_state == G_VGA);
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus queues expected RAM writes and read data,
// a negedge monitor pops and compares them, and a behavioural RAM answers with 1-cycle latency.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        err_overflow;
  logic        vga_req;
  logic [9:0]  vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int          testsRun;
  int          testsFailed;
  wr_entry_t   wq[$];
  logic [31:0] rq[$];
  logic [31:0] ram [1024];
  logic [9:0]  ovAddr [5];
  logic [31:0] ovData [5];

  vram_arbiter #(
    .ADDR_W      (10),
    .DATA_W      (32),
    .FIFO_DEPTH  (4),
    .MAX_VGA_RUN (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .err_overflow (err_overflow),
    .vga_req      (vga_req),
    .vga_addr     (vga_addr),
    .vga_gnt      (vga_gnt),
    .vga_rvalid   (vga_rvalid),
    .vga_rdata    (vga_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with synchronous read, preloaded with a known word at the top address.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h3FF] = 32'h12345678;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
        else mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [31:0] data,
                               input logic vreq, input logic [9:0] vaddr);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    vga_req   = vreq;
    vga_addr  = vaddr;
  endtask

  task automatic queueStore(input logic [9:0] addr, input logic [31:0] data);
    wr_entry_t e;
    e.addr = addr;
    e.data = data;
    wq.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write and every returned VGA word must match the head of its queue.
  always @(negedge clk) begin : monitor
    wr_entry_t   e;
    logic [31:0] r;
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checkOutput("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        e = wq.pop_front();
        checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("wr_data", mem_wdata, e.data);
      end
    end
    if (vga_rvalid === 1'b1) begin
      if (rq.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'(vga_rvalid), 32'd0);
      end else begin
        r = rq.pop_front();
        checkOutput("rd_data", vga_rdata, r);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    ovAddr[0] = 10'h100; ovData[0] = 32'hA0000001;
    ovAddr[1] = 10'h101; ovData[1] = 32'hA0000002;
    ovAddr[2] = 10'h102; ovData[2] = 32'hA0000003;
    ovAddr[3] = 10'h102; ovData[3] = 32'hA0000004;
    ovAddr[4] = 10'h104; ovData[4] = 32'hA0000005;

    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then ten idle cycles with no RAM activity.
    @(negedge clk);
    checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_err_overflow", 32'(err_overflow), 32'd0);
    checkOutput("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("rst_vga_gnt", 32'(vga_gnt), 32'd0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("idle_mem_en_%0d", k), 32'(mem_en), 32'd0);
      nextCycle();
      @(negedge clk);
    end
    nextCycle();

    // Single store with VGA idle: written the following cycle.
    applyStimulus(1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 10'h0);
    queueStore(10'h005, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("store_push_mem_en", 32'(mem_en), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
    @(negedge clk);
    checkOutput("store_mem_we", 32'(mem_we), 32'd1);
    checkOutput("store_mem_addr", 32'(mem_addr), 32'h005);
    checkOutput("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
    nextCycle();
    @(negedge clk);
    checkOutput("store_drained_mem_en", 32'(mem_en), 32'd0);
    nextCycle();

    // Single VGA read: same-cycle grant, data one cycle later.
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b1, 10'h3FF);
    rq.push_back(32'h12345678);
    @(negedge clk);
    checkOutput("rd_vga_gnt", 32'(vga_gnt), 32'd1);
    checkOutput("rd_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rd_mem_addr", 32'(mem_addr), 32'h3FF);
    nextCycle();
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
    @(negedge clk);
    checkOutput("rd_vga_rvalid", 32'(vga_rvalid), 32'd1);
    checkOutput("rd_vga_rdata", vga_rdata, 32'h12345678);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_rvalid_drop", 32'(vga_rvalid), 32'd0);
    nextCycle();

    // Starvation guard: store pushed at k=0 under constant VGA traffic,
    // eight VGA grants at k=1..8, forced CPU slot at k=9, VGA again at k=10.
    for (int k = 0; k <= 10; k++) begin
      logic expGnt;
      expGnt = (k != 9);
      if (k == 0) begin
        applyStimulus(1'b1, 10'h010, 32'hCAFE0001, 1'b1, 10'h3FF);
        queueStore(10'h010, 32'hCAFE0001);
      end else begin
        applyStimulus(1'b0, 10'h0, 32'h0, 1'b1, 10'h3FF);
      end
      if (expGnt) rq.push_back(32'h12345678);
      @(negedge clk);
      checkOutput($sformatf("starve_gnt_%0d", k), 32'(vga_gnt), 32'(expGnt));
      checkOutput($sformatf("starve_we_%0d", k), 32'(mem_we), 32'(!expGnt));
      if (k == 10) checkOutput("starve_rvalid_after_cpu", 32'(vga_rvalid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
    @(negedge clk);
    nextCycle();

    // Overflow: five back-to-back stores under VGA traffic; the fifth is dropped.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, ovAddr[k], ovData[k], 1'b1, 10'h3FF);
      if (k < 4) queueStore(ovAddr[k], ovData[k]);
      rq.push_back(32'h12345678);
      @(negedge clk);
      checkOutput($sformatf("ovf_gnt_%0d", k), 32'(vga_gnt), 32'd1);
      if (k == 3) checkOutput("ovf_stall_before_4th", 32'(cpu_stall), 32'd0);
      if (k == 4) checkOutput("ovf_stall_after_4th", 32'(cpu_stall), 32'd1);
      nextCycle();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
      @(negedge clk);
      if (k == 0) checkOutput("ovf_err_set", 32'(err_overflow), 32'd1);
      checkOutput($sformatf("ovf_drain_we_%0d", k), 32'(mem_we), 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("ovf_stall_clear", 32'(cpu_stall), 32'd0);
    checkOutput("ovf_err_sticky", 32'(err_overflow), 32'd1);
    checkOutput("ovf_idle_mem_en", 32'(mem_en), 32'd0);
    nextCycle();

    // Reset mid-drain: three stores queued behind VGA traffic are discarded.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 10'h200 + 10'(k), 32'hB0000000 + 32'(k), 1'b1, 10'h3FF);
      queueStore(10'h200 + 10'(k), 32'hB0000000 + 32'(k));
      rq.push_back(32'h12345678);
      @(negedge clk);
      checkOutput($sformatf("mid_gnt_%0d", k), 32'(vga_gnt), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b1, 10'h3FF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_cycle_we", 32'(mem_we), 32'd0);
    nextCycle();
    rst = 1'b0;
    wq.delete();
    rq.delete();
    applyStimulus(1'b0, 10'h0, 32'h0, 1'b0, 10'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_mem_en_%0d", k), 32'(mem_en), 32'd0);
      checkOutput($sformatf("post_rst_stall_%0d", k), 32'(cpu_stall), 32'd0);
      if (k == 0) begin
        checkOutput("post_rst_err", 32'(err_overflow), 32'd0);
        checkOutput("post_rst_rvalid", 32'(vga_rvalid), 32'd0);
      end
      nextCycle();
    end

    // Final RAM image and scoreboard drain.
    checkOutput("ram_005", ram[10'h005], 32'hDEADBEEF);
    checkOutput("ram_010", ram[10'h010], 32'hCAFE0001);
    checkOutput("ram_100", ram[10'h100], 32'hA0000001);
    checkOutput("ram_101", ram[10'h101], 32'hA0000002);
    checkOutput("ram_102_later_wins", ram[10'h102], 32'hA0000004);
    checkOutput("ram_104_dropped", ram[10'h104], 32'h0);
    checkOutput("ram_200_discarded", ram[10'h200], 32'h0);
    checkOutput("wq_left", 32'(wq.size()), 32'd0);
    checkOutput("rq_left", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
